memwrite_capture_fifo: RTL and testbench

- Sits downstream of the 8-bit multicycle MIPS + memory (mips_mem) store path.
- Samples every CPU store (memwrite, adr, writedata) into a small FIFO and drains them to a consumer over a valid/ready handshake, such as a UART or trace port.
- Also flags stores to one programmable watch address, e.g. result address 0xEE, with a registered hit pulse and a captured data byte.

---
 rtl/memwrite_capture_fifo_pkg.sv | 25 ++
 rtl/memwrite_capture_fifo_wfifo_core.sv | 70 +++++++
 rtl/memwrite_capture_fifo.sv | 78 +++++++
 tb/tb_memwrite_capture_fifo.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/memwrite_capture_fifo_pkg.sv
// Shared constants and types for the store-capture FIFO.
package memwrite_capture_fifo_pkg;

  // Default bus geometry of the 8-bit multicycle MIPS store path.
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned PTRW_DEF  = 2;

  // Result address the CPU writes its final answer to.
  localparam logic [WIDTH_DEF-1:0] RESULT_ADR = 8'hEE;

  // Occupancy update selected each cycle by the accepted push/pop pair.
  typedef enum logic [1:0] {
    OCC_HOLD = 2'b00,
    OCC_POP  = 2'b01,
    OCC_PUSH = 2'b10,
    OCC_BOTH = 2'b11
  } occ_op_e;

  // Build the occupancy operation from accepted push and pop.
  function automatic occ_op_e occ_op(input logic push_acc, input logic pop_acc);
    return occ_op_e'({push_acc, pop_acc});
  endfunction

endpackage

// File: rtl/memwrite_capture_fifo_wfifo_core.sv
// Generic first-word-fall-through FIFO with separate occupancy counter.
module wfifo_core
  import memwrite_capture_fifo_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PTRW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata_c,
  output logic [PTRW:0]   count,
  output logic            full,
  output logic            empty
);

  localparam int unsigned CNTW = PTRW + 1;

  logic [DW-1:0]   mem [DEPTH];
  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [CNTW-1:0] count_nxt;
  logic            push_acc;
  logic            pop_acc;

  // A push is accepted unless full; a simultaneous pop frees the slot.
  assign pop_acc  = pop & ~empty;
  assign push_acc = push & (~full | pop_acc);

  // Head is masked to zero while nothing is queued.
  assign rdata_c = empty ? '0 : mem[rd_ptr];

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_nxt = count;
    case (occ_op(push_acc, pop_acc))
      OCC_PUSH: count_nxt = count + CNTW'(1);
      OCC_POP:  count_nxt = count - CNTW'(1);
      default:  count_nxt = count;
    endcase
  end

  // Storage write; contents need no reset since reads are masked by empty.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + PTRW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNTW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/memwrite_capture_fifo.sv
// Captures CPU stores into a FIFO, flags overflow and watched-address hits.
module memwrite_capture_fifo
  import memwrite_capture_fifo_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned PTRW  = PTRW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] adr,
  input  logic [WIDTH-1:0] writedata,
  input  logic [WIDTH-1:0] watch_adr,
  input  logic             clr_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_adr,
  output logic [WIDTH-1:0] out_data,
  output logic [PTRW:0]    count,
  output logic             full,
  output logic             overflow,
  output logic             hit,
  output logic [WIDTH-1:0] hit_data
);

  logic [2*WIDTH-1:0] head_c;
  logic               empty;
  logic               pop;
  logic               drop;

  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign drop      = memwrite & full & ~pop;
  assign out_adr   = head_c[2*WIDTH-1:WIDTH];
  assign out_data  = head_c[WIDTH-1:0];

  wfifo_core #(
    .DW    (2 * WIDTH),
    .DEPTH (DEPTH),
    .PTRW  (PTRW)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .push    (memwrite),
    .pop     (pop),
    .wdata   ({adr, writedata}),
    .rdata_c (head_c),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Sticky overflow; a drop in the same cycle beats the clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

  // Watch compare runs regardless of FIFO state, including dropped stores.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit      <= 1'b0;
      hit_data <= '0;
    end else begin
      hit <= memwrite & (adr == watch_adr);
      if (memwrite && (adr == watch_adr)) begin
        hit_data <= writedata;
      end
    end
  end

endmodule

// File: tb/tb_memwrite_capture_fifo.sv
// Directed bench for memwrite_capture_fifo.
module tb_memwrite_capture_fifo;

  logic       clk;
  logic       reset;
  logic       memwrite;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic [7:0] watch_adr;
  logic       clr_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_adr;
  logic [7:0] out_data;
  logic [2:0] count;
  logic       full;
  logic       overflow;
  logic       hit;
  logic [7:0] hit_data;

  int tests;
  int fails;

  memwrite_capture_fifo #(.WIDTH(8), .DEPTH(4), .PTRW(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .watch_adr (watch_adr),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_adr   (out_adr),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .overflow  (overflow),
    .hit       (hit),
    .hit_data  (hit_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push one store with out_ready held low.
  task automatic push_store(input logic [7:0] a, input logic [7:0] d);
    memwrite = 1'b1; adr = a; writedata = d;
    step();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL reset_count got %0d want 0", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", out_valid); end
    tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", full); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
    tests++; if (hit !== 1'b0 || hit_data !== 8'h00) begin fails++; $display("FAIL reset_hit got %b/%h want 0/00", hit, hit_data); end
    tests++; if (out_adr !== 8'h00 || out_data !== 8'h00) begin fails++; $display("FAIL reset_head got %h/%h want 00/00", out_adr, out_data); end
  endtask

  task automatic test_single();
    watch_adr = 8'hEE;
    push_store(8'hEE, 8'hF2);
    tests++; if (out_valid !== 1'b1 || count !== 3'd1) begin fails++; $display("FAIL single_occ got v=%b c=%0d want v=1 c=1", out_valid, count); end
    tests++; if (out_adr !== 8'hEE || out_data !== 8'hF2) begin fails++; $display("FAIL single_head got %h/%h want EE/F2", out_adr, out_data); end
    tests++; if (hit !== 1'b1 || hit_data !== 8'hF2) begin fails++; $display("FAIL single_hit got %b/%h want 1/F2", hit, hit_data); end
    step();
    tests++; if (hit !== 1'b0 || out_valid !== 1'b1) begin fails++; $display("FAIL single_hold got hit=%b v=%b want 0/1", hit, out_valid); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0 || out_adr !== 8'h00) begin fails++; $display("FAIL single_drain got c=%0d v=%b a=%h want 0/0/00", count, out_valid, out_adr); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) push_store(8'h10 + 8'(i), 8'h01 + 8'(i));
    tests++; if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin fails++; $display("FAIL ovf_fill got c=%0d f=%b o=%b want 4/1/0", count, full, overflow); end
    push_store(8'h14, 8'h05);
    tests++; if (count !== 3'd4 || overflow !== 1'b1) begin fails++; $display("FAIL ovf_drop got c=%0d o=%b want 4/1", count, overflow); end
    tests++; if (hit !== 1'b0) begin fails++; $display("FAIL ovf_nohit got %b want 0", hit); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_adr !== 8'h10 + 8'(i) || out_data !== 8'h01 + 8'(i)) begin
        fails++; $display("FAIL ovf_order%0d got v=%b %h/%h want 1 %h/%h", i, out_valid, out_adr, out_data, 8'h10 + 8'(i), 8'h01 + 8'(i));
      end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0) begin fails++; $display("FAIL ovf_empty got v=%b c=%0d f=%b want 0/0/0", out_valid, count, full); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] ea [4];
    logic [7:0] ed [4];
    ea[0] = 8'h41; ea[1] = 8'h42; ea[2] = 8'h43; ea[3] = 8'h20;
    ed[0] = 8'h51; ed[1] = 8'h52; ed[2] = 8'h53; ed[3] = 8'hAA;
    for (int i = 0; i < 4; i++) push_store(8'h40 + 8'(i), 8'h50 + 8'(i));
    memwrite = 1'b1; adr = 8'h20; writedata = 8'hAA; out_ready = 1'b1;
    step();
    memwrite = 1'b0;
    tests++; if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin fails++; $display("FAIL fpp_occ got c=%0d o=%b f=%b want 4/0/1", count, overflow, full); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (out_adr !== ea[i] || out_data !== ed[i]) begin
        fails++; $display("FAIL fpp_order%0d got %h/%h want %h/%h", i, out_adr, out_data, ea[i], ed[i]);
      end
      step();
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fpp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_no_bypass();
    memwrite = 1'b1; adr = 8'h30; writedata = 8'hBB; out_ready = 1'b1;
    step();
    memwrite = 1'b0;
    tests++; if (count !== 3'd1 || out_valid !== 1'b1 || out_adr !== 8'h30 || out_data !== 8'hBB) begin
      fails++; $display("FAIL nobyp_visible got c=%0d v=%b %h/%h want 1 1 30/BB", count, out_valid, out_adr, out_data);
    end
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL nobyp_popped got c=%0d v=%b want 0/0", count, out_valid); end
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      memwrite = 1'b1; adr = 8'h60 + 8'(i); writedata = 8'h70 + 8'(i);
      step();
      memwrite = 1'b0;
      if (out_valid !== 1'b1 || out_adr !== 8'h60 + 8'(i) || out_data !== 8'h70 + 8'(i) || count !== 3'd1) begin
        bad++; $display("FAIL wrap_item%0d got v=%b %h/%h c=%0d", i, out_valid, out_adr, out_data, count);
      end
      step();
      if (count !== 3'd0) begin bad++; $display("FAIL wrap_gap%0d got c=%0d want 0", i, count); end
    end
    out_ready = 1'b0;
    tests++; if (bad != 0) begin fails++; $display("FAIL wrap_total got %0d errors want 0", bad); end
  endtask

  task automatic test_back_to_back();
    watch_adr = 8'hEE;
    memwrite = 1'b1; adr = 8'hEE; writedata = 8'h01;
    step();
    tests++; if (hit !== 1'b1 || hit_data !== 8'h01) begin fails++; $display("FAIL b2b_first got %b/%h want 1/01", hit, hit_data); end
    writedata = 8'h02;
    step();
    tests++; if (hit !== 1'b1 || hit_data !== 8'h02) begin fails++; $display("FAIL b2b_second got %b/%h want 1/02", hit, hit_data); end
    adr = 8'hEF; writedata = 8'h03;
    step();
    memwrite = 1'b0;
    tests++; if (hit !== 1'b0 || hit_data !== 8'h02) begin fails++; $display("FAIL b2b_nearmiss got %b/%h want 0/02", hit, hit_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd0) begin fails++; $display("FAIL b2b_drain got c=%0d want 0", count); end
  endtask

  task automatic test_clr_with_drop();
    watch_adr = 8'hEE;
    for (int i = 0; i < 4; i++) push_store(8'h80 + 8'(i), 8'h90 + 8'(i));
    memwrite = 1'b1; adr = 8'hEE; writedata = 8'h5A; clr_ovf = 1'b1;
    step();
    memwrite = 1'b0; clr_ovf = 1'b0;
    tests++; if (overflow !== 1'b1 || count !== 3'd4) begin fails++; $display("FAIL clrdrop_ovf got o=%b c=%0d want 1/4", overflow, count); end
    tests++; if (hit !== 1'b1 || hit_data !== 8'h5A) begin fails++; $display("FAIL clrdrop_hit got %b/%h want 1/5A", hit, hit_data); end
    tests++; if (out_adr !== 8'h80 || out_data !== 8'h90) begin fails++; $display("FAIL clrdrop_head got %h/%h want 80/90", out_adr, out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    tests++; if (count !== 3'd3 || overflow !== 1'b1) begin fails++; $display("FAIL arst_pre got c=%0d o=%b want 3/1", count, overflow); end
    #2 reset = 1'b0;
    #1;
    tests++; if (count !== 3'd0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL arst_now got c=%0d v=%b o=%b want 0/0/0", count, out_valid, overflow);
    end
    tests++; if (out_adr !== 8'h00 || full !== 1'b0 || hit_data !== 8'h00) begin fails++; $display("FAIL arst_rest got a=%h f=%b hd=%h want 00/0/00", out_adr, full, hit_data); end
    step();
    reset = 1'b1;
    step();
    tests++; if (count !== 3'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL arst_after got c=%0d v=%b want 0/0", count, out_valid); end
  endtask

  initial begin
    tests = 0; fails = 0;
    reset = 1'b0; memwrite = 1'b0; adr = '0; writedata = '0;
    watch_adr = 8'hEE; clr_ovf = 1'b0; out_ready = 1'b0;
    step();
    test_reset();
    step();
    reset = 1'b1;
    step();
    test_single();
    test_overflow();
    test_full_push_pop();
    test_no_bypass();
    test_wrap();
    test_back_to_back();
    test_clr_with_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
